// File: rtl/dadda_pkg.sv
// Shared constants for the Dadda multiplier family: the reduction height
// sequence and a helper that sizes the reduction tree from the operand width.
package dadda_pkg;

  localparam int MAX_WIDTH = 16;
  localparam int DADDA_D [0:7] = '{2, 3, 4, 6, 9, 13, 19, 28};

  // One reduction stage per sequence entry that is below the tallest column.
  function automatic int dadda_stages(input int width);
    int n;
    n = 0;
    for (int k = 0; k < 8; k++) begin
      if (DADDA_D[k] < width) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/dadda_reduce.sv
// Combinational Baugh-Wooley partial-product matrix reduced to two rows by a
// Dadda tree of fa/ha cells; each stage's column layout is derived at elaboration.
module dadda_reduce
  import dadda_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               mode,
  output logic [2*WIDTH-1:0] sum_row,
  output logic [2*WIDTH-1:0] carry_row
);

  localparam int COLS = 2 * WIDTH;
  localparam int NST  = dadda_stages(WIDTH);

  localparam int SEL_FA   = 0;
  localparam int SEL_HA   = 1;
  localparam int SEL_H    = 2;
  localparam int SEL_OFF  = 3;
  localparam int SEL_COFF = 4;
  localparam int SEL_CIN  = 5;

  function automatic int pp_cnt(input int c);
    if (c < WIDTH) return c + 1;
    else if (c < COLS - 1) return COLS - 1 - c;
    else return 0;
  endfunction

  function automatic int imin(input int c);
    return (c >= WIDTH) ? c - WIDTH + 1 : 0;
  endfunction

  function automatic int init_h(input int c);
    return pp_cnt(c) + (((c == WIDTH) || (c == COLS - 1)) ? 1 : 0);
  endfunction

  // Replays the Dadda schedule up to stage s. The top column is never reduced:
  // only its parity survives truncation, so it just collects carries.
  function automatic int dinfo(input int s, input int c, input int sel);
    int h  [2*MAX_WIDTH];
    int nf [2*MAX_WIDTH];
    int nh [2*MAX_WIDTH];
    int cin, r, d, acc_h, acc_c, res;
    res = 0;
    for (int i = 0; i < COLS; i++) h[i] = init_h(i);
    for (int k = 0; k <= s; k++) begin
      d     = (k < NST) ? DADDA_D[NST-1-k] : 0;
      cin   = 0;
      acc_h = 0;
      acc_c = 0;
      for (int i = 0; i < COLS; i++) begin
        nf[i] = 0;
        nh[i] = 0;
        if ((k < NST) && (i < COLS - 1)) begin
          r = h[i] + cin - d;
          if (r > 0) begin
            nf[i] = r / 2;
            nh[i] = r % 2;
          end
        end
        if ((k == s) && (i == c)) begin
          if (sel == SEL_FA) res = nf[i];
          else if (sel == SEL_HA) res = nh[i];
          else if (sel == SEL_H) res = h[i];
          else if (sel == SEL_OFF) res = acc_h;
          else if (sel == SEL_COFF) res = acc_c;
          else res = cin;
        end
        acc_h += h[i];
        acc_c += nf[i] + nh[i];
        cin = nf[i] + nh[i];
      end
      if ((k == s) && (c == COLS)) res = (sel == SEL_OFF) ? acc_h : acc_c;
      for (int i = COLS - 1; i >= 0; i--) begin
        h[i] = h[i] - 2 * nf[i] - nh[i] + ((i > 0) ? nf[i-1] + nh[i-1] : 0);
      end
    end
    return res;
  endfunction

  for (genvar s = 0; s <= NST; s++) begin : g_st
    logic [dinfo(s, COLS, SEL_OFF)-1:0] v;
    if (s == 0) begin : g_pp
      for (genvar i = 0; i < WIDTH; i++) begin : g_i
        for (genvar j = 0; j < WIDTH; j++) begin : g_j
          localparam int   C   = i + j;
          localparam logic INV = ((i == WIDTH - 1) != (j == WIDTH - 1));
          assign v[dinfo(0, C, SEL_OFF) + i - imin(C)] = (a[i] & b[j]) ^ (mode & INV);
        end
      end
      // Baugh-Wooley correction ones, present only for signed beats.
      assign v[dinfo(0, WIDTH, SEL_OFF) + pp_cnt(WIDTH)] = mode;
      assign v[dinfo(0, COLS - 1, SEL_OFF)] = mode;
    end else begin : g_red
      logic [dinfo(s-1, COLS, SEL_COFF)-1:0] cy;
      for (genvar c = 0; c < COLS; c++) begin : g_col
        localparam int NF  = dinfo(s - 1, c, SEL_FA);
        localparam int NH  = dinfo(s - 1, c, SEL_HA);
        localparam int PH  = dinfo(s - 1, c, SEL_H);
        localparam int PB  = dinfo(s - 1, c, SEL_OFF);
        localparam int CB  = dinfo(s - 1, c, SEL_COFF);
        localparam int CIN = dinfo(s - 1, c, SEL_CIN);
        localparam int OB  = dinfo(s, c, SEL_OFF);
        localparam int NP  = PH - 3 * NF - 2 * NH;
        for (genvar k = 0; k < NP; k++) begin : g_pass
          assign v[OB+k] = g_st[s-1].v[PB+3*NF+2*NH+k];
        end
        for (genvar k = 0; k < NF; k++) begin : g_fa
          fa u_fa (
            .a  (g_st[s-1].v[PB+3*k]),
            .b  (g_st[s-1].v[PB+3*k+1]),
            .ci (g_st[s-1].v[PB+3*k+2]),
            .s  (v[OB+NP+k]),
            .co (cy[CB+k])
          );
        end
        for (genvar k = 0; k < NH; k++) begin : g_ha
          ha u_ha (
            .a  (g_st[s-1].v[PB+3*NF+2*k]),
            .b  (g_st[s-1].v[PB+3*NF+2*k+1]),
            .s  (v[OB+NP+NF+k]),
            .co (cy[CB+NF+k])
          );
        end
        for (genvar k = 0; k < CIN; k++) begin : g_cin
          assign v[OB+NP+NF+NH+k] = cy[CB-CIN+k];
        end
      end
    end
  end

  for (genvar c = 0; c < COLS - 1; c++) begin : g_out
    assign sum_row[c] = g_st[NST].v[dinfo(NST, c, SEL_OFF)];
    if (dinfo(NST, c, SEL_H) == 2) begin : g_two
      assign carry_row[c] = g_st[NST].v[dinfo(NST, c, SEL_OFF) + 1];
    end else begin : g_one
      assign carry_row[c] = 1'b0;
    end
  end
  assign sum_row[COLS-1]   = ^g_st[NST].v[dinfo(NST, COLS - 1, SEL_OFF) +: dinfo(NST, COLS - 1, SEL_H)];
  assign carry_row[COLS-1] = 1'b0;

endmodule

// File: rtl/fa.sv
// Full-adder cell from the shared arithmetic cell library.
module fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/ha.sv
// Half-adder cell from the shared arithmetic cell library.
module ha (
  input  logic a,
  input  logic b,
  output logic s,
  output logic co
);
  assign s  = a ^ b;
  assign co = a & b;
endmodule

// File: rtl/dadda_mult_pipe.sv
// Three-stage streaming multiplier: operand capture, Dadda reduction, and a
// ripple carry-propagate add, all advancing together under one stall signal.
module dadda_mult_pipe
  import dadda_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p
);

  localparam int PW = 2 * WIDTH;

  // Handshake: a beat transfers on a cycle where valid && ready. The whole
  // pipe moves when the output slot is empty or being popped; otherwise every
  // stage (bubbles included) holds, and in_ready drops in the same cycle.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  logic             s1_valid, s1_signed;
  logic [WIDTH-1:0] s1_a, s1_b;
  logic             s2_valid;
  logic [PW-1:0]    s2_sum, s2_carry;
  logic [PW-1:0]    red_sum, red_carry;
  logic [PW-1:0]    sum_p;
  logic [PW-2:0]    rc;

  dadda_reduce #(.WIDTH(WIDTH)) u_reduce (
    .a         (s1_a),
    .b         (s1_b),
    .mode      (s1_signed),
    .sum_row   (red_sum),
    .carry_row (red_carry)
  );

  ha u_add0 (
    .a  (s2_sum[0]),
    .b  (s2_carry[0]),
    .s  (sum_p[0]),
    .co (rc[0])
  );
  for (genvar i = 1; i < PW - 1; i++) begin : g_add
    fa u_add (
      .a  (s2_sum[i]),
      .b  (s2_carry[i]),
      .ci (rc[i-1]),
      .s  (sum_p[i]),
      .co (rc[i])
    );
  end
  // Carry out of the top bit is dropped: the product is exact in PW bits.
  assign sum_p[PW-1] = s2_sum[PW-1] ^ s2_carry[PW-1] ^ rc[PW-2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_signed <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s2_valid  <= 1'b0;
      s2_sum    <= '0;
      s2_carry  <= '0;
      out_valid <= 1'b0;
      out_p     <= '0;
    end else if (adv) begin
      s1_valid  <= in_valid;
      s1_signed <= in_signed;
      s1_a      <= in_a;
      s1_b      <= in_b;
      s2_valid  <= s1_valid;
      s2_sum    <= red_sum;
      s2_carry  <= red_carry;
      out_valid <= s2_valid;
      out_p     <= sum_p;
    end
  end

endmodule

// File: tb/tb_dadda_mult_pipe.sv
// Bench for dadda_mult_pipe at widths 8, 4 and 16 with an arithmetic reference
// model and per-width expected-product queues.
module tb_dadda_mult_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        v8, r8, s8, ov8, or8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;
  logic        v4, r4, s4, ov4, or4;
  logic [3:0]  a4, b4;
  logic [7:0]  p4;
  logic        v16, r16, s16, ov16, or16;
  logic [15:0] a16, b16;
  logic [31:0] p16;

  dadda_mult_pipe #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(r8), .in_a(a8), .in_b(b8),
    .in_signed(s8), .out_valid(ov8), .out_ready(or8), .out_p(p8));
  dadda_mult_pipe #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_ready(r4), .in_a(a4), .in_b(b4),
    .in_signed(s4), .out_valid(ov4), .out_ready(or4), .out_p(p4));
  dadda_mult_pipe #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(v16), .in_ready(r16), .in_a(a16), .in_b(b16),
    .in_signed(s16), .out_valid(ov16), .out_ready(or16), .out_p(p16));

  logic [15:0] q8[$];
  logic [7:0]  q4[$];
  logic [31:0] q16[$];
  int checks = 0;
  int errors = 0;
  bit f8, f4, f16;
  logic [15:0] hold;
  int i4, i8, i16, cyc;

  logic [7:0]  da[8] = '{8'hFF, 8'h80, 8'hFF, 8'h7F, 8'h00, 8'h03, 8'hFF, 8'hFF};
  logic [7:0]  db[8] = '{8'hFF, 8'h80, 8'h01, 8'h80, 8'h00, 8'h05, 8'hFF, 8'hFF};
  logic        ds[8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [15:0] dp[8] = '{16'hFE01, 16'h4000, 16'hFFFF, 16'hC080,
                         16'h0000, 16'h000F, 16'hFE01, 16'h0001};

  function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b,
                                          input logic sgn, input int w);
    longint sa, sb, pr;
    sa = longint'(a);
    sb = longint'(b);
    if (sgn && a[w-1]) sa = sa - (longint'(1) << w);
    if (sgn && b[w-1]) sb = sb - (longint'(1) << w);
    pr = (sa * sb) & ((longint'(1) << (2 * w)) - 1);
    return pr[31:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: score handshakes mid-cycle, then return just after the edge.
  task automatic tick();
    @(negedge clk);
    f8  = v8 && r8;
    f4  = v4 && r4;
    f16 = v16 && r16;
    if (ov8 && or8) begin
      chk("w8_spurious", 32'(q8.size() != 0), 32'd1);
      if (q8.size() != 0) chk("w8_product", 32'(p8), 32'(q8.pop_front()));
    end
    if (ov4 && or4) begin
      chk("w4_spurious", 32'(q4.size() != 0), 32'd1);
      if (q4.size() != 0) chk("w4_product", 32'(p4), 32'(q4.pop_front()));
    end
    if (ov16 && or16) begin
      chk("w16_spurious", 32'(q16.size() != 0), 32'd1);
      if (q16.size() != 0) chk("w16_product", p16, q16.pop_front());
    end
    if (f8)  q8.push_back(16'(ref_mul({8'h00, a8}, {8'h00, b8}, s8, 8)));
    if (f4)  q4.push_back(8'(ref_mul({12'h000, a4}, {12'h000, b4}, s4, 4)));
    if (f16) q16.push_back(ref_mul(a16, b16, s16, 16));
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    v8 = 0; a8 = 0; b8 = 0; s8 = 0; or8 = 1;
    v4 = 0; a4 = 0; b4 = 0; s4 = 0; or4 = 1;
    v16 = 0; a16 = 0; b16 = 0; s16 = 0; or16 = 1;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ov8", 32'(ov8), 32'd0);
    chk("reset_p8", 32'(p8), 32'd0);
    chk("reset_ov4", 32'(ov4), 32'd0);
    chk("reset_p4", 32'(p4), 32'd0);
    chk("reset_ov16", 32'(ov16), 32'd0);
    chk("reset_p16", p16, 32'd0);
    chk("reset_ready8", 32'(r8), 32'd1);
    rst = 1'b0;
    tick();
    chk("ready_after_reset", 32'(r8), 32'd1);
    chk("valid_after_reset", 32'(ov8), 32'd0);

    // 15 x 15 unsigned must emerge exactly three edges after acceptance.
    a8 = 8'd15; b8 = 8'd15; s8 = 1'b0; v8 = 1'b1;
    tick();
    chk("lat_accept", 32'(f8), 32'd1);
    v8 = 1'b0;
    chk("lat_edge1", 32'(ov8), 32'd0);
    tick();
    chk("lat_edge2", 32'(ov8), 32'd0);
    tick();
    chk("lat_edge3_valid", 32'(ov8), 32'd1);
    chk("lat_edge3_p", 32'(p8), 32'h0000_00E1);

    // Corner products and a mixed-mode back-to-back stream.
    for (int t = 0; t < 10; t++) begin
      if (t < 8) begin
        a8 = da[t]; b8 = db[t]; s8 = ds[t]; v8 = 1'b1;
      end else begin
        v8 = 1'b0;
      end
      tick();
      if (t >= 2) begin
        chk("dir_valid", 32'(ov8), 32'd1);
        chk("dir_p", 32'(p8), 32'(dp[t-2]));
      end
    end

    // Fill, then stall the output for four cycles with a beat waiting.
    for (int t = 0; t < 3; t++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom); v8 = 1'b1;
      tick();
    end
    hold = p8;
    a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom);
    or8 = 1'b0;
    for (int t = 0; t < 4; t++) begin
      tick();
      chk("stall_ready", 32'(r8), 32'd0);
      chk("stall_valid", 32'(ov8), 32'd1);
      chk("stall_hold", 32'(p8), 32'(hold));
    end
    or8 = 1'b1;
    tick();
    v8 = 1'b0;
    repeat (5) tick();
    chk("stall_drain_empty", 32'(q8.size()), 32'd0);

    // Asynchronous reset with beats in flight.
    for (int t = 0; t < 3; t++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom); v8 = 1'b1;
      tick();
    end
    v8 = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_async_valid", 32'(ov8), 32'd0);
    chk("rst_async_p", 32'(p8), 32'd0);
    q8.delete();
    q4.delete();
    q16.delete();
    rst = 1'b0;
    for (int t = 0; t < 5; t++) begin
      tick();
      chk("rst_no_stale", 32'(ov8), 32'd0);
    end
    a8 = 8'hF9; b8 = 8'h09; s8 = 1'b1; v8 = 1'b1;
    tick();
    v8 = 1'b0;
    repeat (2) tick();
    chk("post_rst_valid", 32'(ov8), 32'd1);
    chk("post_rst_p", 32'(p8), 32'h0000_FFC1);

    // Randomised traffic with backpressure: exhaustive at 4 bits, random at 8/16.
    i4 = 0; i8 = 0; i16 = 0; cyc = 0;
    a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom);
    a16 = 16'($urandom); b16 = 16'($urandom); s16 = 1'($urandom);
    f8 = 0; f4 = 0; f16 = 0;
    while ((i4 < 512 || i8 < 2000 || i16 < 10000) && cyc < 40000) begin
      a4 = i4[3:0]; b4 = i4[7:4]; s4 = i4[8];
      v4  = (i4 < 512) && ((v4 && !f4) || ($urandom_range(0, 9) < 8));
      v8  = (i8 < 2000) && ((v8 && !f8) || ($urandom_range(0, 9) < 8));
      v16 = (i16 < 10000) && ((v16 && !f16) || ($urandom_range(0, 9) < 8));
      or4  = ($urandom_range(0, 3) != 0);
      or8  = ($urandom_range(0, 3) != 0);
      or16 = ($urandom_range(0, 3) != 0);
      tick();
      if (f4) i4++;
      if (f8) begin
        i8++;
        a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom);
      end
      if (f16) begin
        i16++;
        a16 = 16'($urandom); b16 = 16'($urandom); s16 = 1'($urandom);
      end
      cyc++;
    end
    chk("rand_done", 32'(i4 == 512 && i8 == 2000 && i16 == 10000), 32'd1);
    v4 = 0; v8 = 0; v16 = 0; or4 = 1; or8 = 1; or16 = 1;
    repeat (6) tick();
    chk("final_empty_w4", 32'(q4.size()), 32'd0);
    chk("final_empty_w8", 32'(q8.size()), 32'd0);
    chk("final_empty_w16", 32'(q16.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
